// File: rtl/multicycle_ctrl.sv
// Multicycle datapath control FSM: fetch, decode, execute, memory and write-back sequencing.
// Define RETIRE_COUNT_EN to build the retired-instruction counter; otherwise retired reads 0.
module multicycle_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 mem_ready,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCWriteCond,
    output logic                 PCSource,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic                 RegWrite,
    output logic                 MemtoReg,
    output logic                 instr_done,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EX_R, S_EX_I, S_EX_LS, S_EX_BR,
        S_MEM_LD, S_MEM_ST, S_WB_ALU, S_WB_LD, S_HALT
    } state_t;

    state_t state, next_state;

    always_ff @(posedge clock) begin
        if (reset) state <= S_IF;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUOp       = 2'b00;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        instr_done  = 1'b0;
        halted      = 1'b0;
        case (state)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) next_state = S_ID;
            end
            // ID precomputes the branch target into ALUOut while decoding
            S_ID: begin
                ALUSrcB = 2'd3;
                case (opcode)
                    OP_R:         next_state = S_EX_R;
                    OP_I:         next_state = S_EX_I;
                    OP_LD, OP_ST: next_state = S_EX_LS;
                    OP_BR:        next_state = S_EX_BR;
                    default:      next_state = S_HALT;
                endcase
            end
            S_EX_R: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                next_state = S_WB_ALU;
            end
            S_EX_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd2;
                ALUOp      = 2'b10;
                next_state = S_WB_ALU;
            end
            S_EX_LS: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd2;
                next_state = (opcode == OP_LD) ? S_MEM_LD : S_MEM_ST;
            end
            S_EX_BR: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                instr_done  = 1'b1;
                next_state  = S_IF;
            end
            S_MEM_LD: begin
                MemRead = 1'b1;
                if (mem_ready) next_state = S_WB_LD;
            end
            S_MEM_ST: begin
                MemWrite = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    next_state = S_IF;
                end
            end
            S_WB_ALU: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                next_state = S_IF;
            end
            S_WB_LD: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                next_state = S_IF;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: next_state = S_IF;
        endcase
    end

`ifdef RETIRE_COUNT_EN
    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset)           count <= '0;
        else if (instr_done) count <= count + 1'b1;
    end

    assign retired = count;
`else
    assign retired = '0;
`endif

endmodule
